cci_mpf_shim_nch_req_merge: RTL
===============================

// Module: cci_mpf_shim_nch_req_merge
// PURPOSE
//  Parametrised N-channel request buffer/merge stage for the MPF pipeline.
//  Each AFU-side request channel feeds its own FIFO under CCI-P almost-full flow control.
//  A round-robin arbiter merges the FIFOs onto one FIU-side request stream, tagged with the source channel.
//  Sits between the AFU edge and downstream shims; replaces the fixed two-channel buffering in the edge.
// PARAMETERS
//  N_CHANNELS    2    number of AFU request channels, 1..8
//  DATA_WIDTH    600  bits per request (header + payload), opaque to this block
//  N_ENTRIES     16   FIFO depth per channel; power of 2, >= THRESHOLD+2
//  THRESHOLD     8    almost-full slack: requests a producer may still send after seeing afu_almost_full
// PORTS
//  clk              in   1                      clock
//  reset            in   1                      synchronous, active-high
//  afu_valid        in   N_CHANNELS             request valid, per channel
//  afu_data         in   N_CHANNELS*DATA_WIDTH  request payload; channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//  afu_almost_full  out  N_CHANNELS             per-channel backpressure
//  fiu_valid        out  1                      merged request valid
//  fiu_data         out  DATA_WIDTH             merged request payload
//  fiu_chan         out  $clog2(N_CHANNELS)     source channel of fiu_data (width 1 when N_CHANNELS=1)
//  fiu_almost_full  in   1                      downstream backpressure
//  occupancy        out  N_CHANNELS*$clog2(N_ENTRIES+1)  per-channel FIFO fill level
//  err_overflow     out  N_CHANNELS             sticky: request arrived while the FIFO was full
// BEHAVIOUR
//  - Reset: fiu_valid=0, fiu_data=0, fiu_chan=0, occupancy=0, err_overflow=0.
//    afu_almost_full is all-ones while reset is high and recomputes on the first cycle after.
//    All FIFO contents are discarded; RR pointer returns to 0.
//    Reset mid-operation is identical: in-flight requests are dropped silently.
//  - Enqueue: afu_valid[i] at edge t writes FIFO i; the entry is visible to the arbiter in cycle t+1.
//    There is no ready signal; the producer relies on afu_almost_full.
//  - afu_almost_full[i] is a registered flag:
//    (occupancy[i] after this edge's enq/deq) >= N_ENTRIES-THRESHOLD.
//  - Full: if occupancy[i]==N_ENTRIES and no dequeue of i this cycle, a write is dropped and err_overflow[i] sets.
//    err_overflow stays set until reset.
//    Full with a simultaneous dequeue of i: the write is accepted and occupancy is unchanged.
//  - Arbitration, once per cycle: if !fiu_almost_full and any FIFO is non-empty, grant one channel.
//    Search starts at (last_grant+1) mod N_CHANNELS. After reset the search starts at channel 0.
//    The granted FIFO pops; data and channel are registered into fiu_data/fiu_chan with fiu_valid=1 the next cycle.
//    Otherwise fiu_valid=0 next cycle and fiu_data holds its previous value.
//  - fiu_almost_full is sampled in the grant cycle; the response to it is 1 cycle.
//    At most one request issues after it rises.
//  - Latency: empty FIFO, unthrottled: afu_valid at cycle t -> fiu_valid at cycle t+2.
//  - Throughput: 1 request/cycle aggregate; per-channel FIFO order is preserved.
//    No ordering holds across channels.
//  - Arbiter is fair: with all channels backlogged each channel gets exactly 1 of every N_CHANNELS grants.
//  - Simultaneous enq+deq on one channel: occupancy unchanged. Empty FIFO with enq: not grantable until next cycle.
//  - Occupancy width $clog2(N_ENTRIES+1); counts 0..N_ENTRIES with no wrap.
//    FIFO read/write pointers are $clog2(N_ENTRIES) bits and wrap naturally.
// STRUCTURE
//  - Package cci_mpf_shim_nch_req_merge_pkg: t_chan_idx, t_occupancy typedefs.
//    Also a function computing the almost-full limit (N_ENTRIES-THRESHOLD) with elaboration-time
//    checks of the parameter legality rules.
//  - Sub-module cci_mpf_shim_nch_fifo: one per channel via generate.
//    Contents: LUTRAM storage, pointers, occupancy counter, registered almost-full, overflow flag.
//  - Top level: generate loop, RR arbiter (rotate-mask priority encoder), output register.
// TESTING
//  1 Reset: hold reset 3 cycles -> afu_almost_full=2'b11, fiu_valid=0. Release -> afu_almost_full=2'b00 next cycle.
//  2 Latency: single afu_valid[0], data=0xA5 at t -> fiu_valid=1, fiu_data=0xA5, fiu_chan=0 at t+2 only.
//  3 Fairness: preload 4 requests on each of 3 channels, then release fiu_almost_full -> fiu_chan sequence 0,1,2,0,1,2,...
//    No gaps; 12 grants total.
//  4 Backpressure: N_ENTRIES=16, THRESHOLD=8, fiu_almost_full=1.
//    8 writes to ch1 -> afu_almost_full[1]=1 in the cycle after the 8th.
//    8 more writes are accepted (occupancy=16, no error); a 17th sets err_overflow[1] and occupancy stays 16.
//  5 Full + dequeue: occupancy=16, drop fiu_almost_full and write the same cycle -> no error, occupancy stays 16.
//    FIFO order preserved.
//  6 Mid-op reset: 5 entries queued, fiu_valid active, assert reset 1 cycle -> next cycle fiu_valid=0 and occupancy=0.
//    Subsequent first grant is channel 0.

Source files
------------

// File: rtl/cci_mpf_shim_nch_req_merge_pkg.sv
// Shared types and parameter helpers for the N-channel request merge.
// Sizes here are upper bounds; modules narrow them to their own parameters.
package cci_mpf_shim_nch_req_merge_pkg;

  localparam int MAX_CHANNELS = 8;
  localparam int MAX_ENTRIES  = 1024;

  typedef logic [$clog2(MAX_CHANNELS)-1:0]  t_chan_idx;
  typedef logic [$clog2(MAX_ENTRIES+1)-1:0] t_occupancy;

  function automatic bit params_legal(
    input int n_ch,
    input int n_ent,
    input int thr
  );
    bit ok;
    ok = (n_ch >= 1) && (n_ch <= MAX_CHANNELS);
    ok = ok && (n_ent >= 2) && (n_ent <= MAX_ENTRIES);
    ok = ok && ((n_ent & (n_ent - 1)) == 0);
    ok = ok && (thr >= 0) && (n_ent >= thr + 2);
    return ok;
  endfunction

  // Fill level at which a producer must stop sending.
  function automatic t_occupancy af_limit(
    input int n_ent,
    input int thr
  );
    return t_occupancy'(n_ent - thr);
  endfunction

endpackage

// File: rtl/cci_mpf_shim_nch_req_merge_fifo.sv
// Per-channel request FIFO with occupancy count, registered
// almost-full and a sticky overflow flag.
module cci_mpf_shim_nch_fifo
  import cci_mpf_shim_nch_req_merge_pkg::*;
#(
  parameter int DATA_WIDTH = 600,
  parameter int N_ENTRIES  = 16,
  parameter int THRESHOLD  = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enq,
  input  logic [DATA_WIDTH-1:0]            enq_data,
  input  logic                             deq,
  output logic [DATA_WIDTH-1:0]            first,
  output logic                             notempty,
  output logic [$clog2(N_ENTRIES+1)-1:0]   occupancy,
  output logic                             almost_full,
  output logic                             err_overflow
);

  localparam int PW = $clog2(N_ENTRIES);
  localparam int OW = $clog2(N_ENTRIES+1);
  localparam t_occupancy AF_LIM = af_limit(N_ENTRIES, THRESHOLD);

  logic [DATA_WIDTH-1:0] mem [N_ENTRIES];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  full;
  logic                  accept;
  logic [OW-1:0]         occ_nxt;

  assign full     = (occupancy == OW'(N_ENTRIES));
  assign notempty = (occupancy != '0);
  // A full FIFO still takes a write when it pops the same cycle.
  assign accept   = enq && (!full || deq);
  assign first    = mem[rd_ptr];

  always_comb begin
    occ_nxt = occupancy;
    if (accept && !deq) begin
      occ_nxt = occupancy + OW'(1);
    end else if (!accept && deq) begin
      occ_nxt = occupancy - OW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occupancy    <= '0;
      almost_full  <= 1'b1;
      err_overflow <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (deq) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      occupancy   <= occ_nxt;
      almost_full <= (t_occupancy'(occ_nxt) >= AF_LIM);
      if (enq && !accept) begin
        err_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= enq_data;
    end
  end

endmodule

// File: rtl/cci_mpf_shim_nch_req_merge.sv
// N-channel request buffer and round-robin merge onto one
// FIU-side stream tagged with the source channel.
module cci_mpf_shim_nch_req_merge
  import cci_mpf_shim_nch_req_merge_pkg::*;
#(
  parameter int N_CHANNELS = 2,
  parameter int DATA_WIDTH = 600,
  parameter int N_ENTRIES  = 16,
  parameter int THRESHOLD  = 8,
  localparam int CW = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1,
  localparam int OW = $clog2(N_ENTRIES+1)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [N_CHANNELS-1:0]          afu_valid,
  input  logic [N_CHANNELS*DATA_WIDTH-1:0] afu_data,
  output logic [N_CHANNELS-1:0]          afu_almost_full,
  output logic                           fiu_valid,
  output logic [DATA_WIDTH-1:0]          fiu_data,
  output logic [CW-1:0]                  fiu_chan,
  input  logic                           fiu_almost_full,
  output logic [N_CHANNELS*OW-1:0]       occupancy,
  output logic [N_CHANNELS-1:0]          err_overflow
);

  if (!params_legal(N_CHANNELS, N_ENTRIES, THRESHOLD)) begin : g_bad
    $error("cci_mpf_shim_nch_req_merge: illegal parameters");
  end

  logic [N_CHANNELS-1:0] req;
  logic [N_CHANNELS-1:0] deq;
  logic [N_CHANNELS-1:0] mask;
  logic [N_CHANNELS-1:0] masked;
  logic [DATA_WIDTH-1:0] head [N_CHANNELS];
  logic [DATA_WIDTH-1:0] sel_data;
  t_chan_idx             rr_ptr;
  t_chan_idx             rr_nxt;
  t_chan_idx             gnt_idx;
  logic                  gnt;

  for (genvar i = 0; i < N_CHANNELS; i++) begin : g_ch
    cci_mpf_shim_nch_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .N_ENTRIES  (N_ENTRIES),
      .THRESHOLD  (THRESHOLD)
    ) u_fifo (
      .clk          (clk),
      .reset        (reset),
      .enq          (afu_valid[i]),
      .enq_data     (afu_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .deq          (deq[i]),
      .first        (head[i]),
      .notempty     (req[i]),
      .occupancy    (occupancy[i*OW +: OW]),
      .almost_full  (afu_almost_full[i]),
      .err_overflow (err_overflow[i])
    );
  end

  // Rotate-mask encoder: lowest requester at or above rr_ptr,
  // falling back to the lowest requester overall.
  always_comb begin
    mask = '0;
    for (int i = 0; i < N_CHANNELS; i++) begin
      mask[i] = (t_chan_idx'(i) >= rr_ptr);
    end
    masked  = req & mask;
    gnt_idx = '0;
    for (int i = N_CHANNELS-1; i >= 0; i--) begin
      if (req[i]) gnt_idx = t_chan_idx'(i);
    end
    for (int i = N_CHANNELS-1; i >= 0; i--) begin
      if (masked[i]) gnt_idx = t_chan_idx'(i);
    end
  end

  assign gnt = !fiu_almost_full && (|req);

  always_comb begin
    deq      = '0;
    sel_data = head[0];
    for (int i = 0; i < N_CHANNELS; i++) begin
      if (gnt_idx == t_chan_idx'(i)) begin
        deq[i]   = gnt;
        sel_data = head[i];
      end
    end
  end

  assign rr_nxt = (gnt_idx == t_chan_idx'(N_CHANNELS-1))
                ? '0 : gnt_idx + t_chan_idx'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      fiu_valid <= 1'b0;
      fiu_data  <= '0;
      fiu_chan  <= '0;
      rr_ptr    <= '0;
    end else begin
      fiu_valid <= gnt;
      if (gnt) begin
        fiu_data <= sel_data;
        fiu_chan <= gnt_idx[CW-1:0];
        rr_ptr   <= rr_nxt;
      end
    end
  end

endmodule
